// File: rtl/keyproto_pkg.sv
// Shared types and command codes for the two-key serial command protocol.
package keyproto_pkg;

  localparam int unsigned FRAME_DATA_BITS = 4;

  typedef logic [FRAME_DATA_BITS-1:0] code_t;

  localparam code_t CODE_ON  = 4'b1001;
  localparam code_t CODE_OFF = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BIT,
    STOP
  } tx_state_e;

endpackage

// File: rtl/key_conditioner.sv
// Per-key conditioning: 2-flop synchroniser, optional debounce, registered rising-edge pulse.
// Debounce is built only when KEY_DEBOUNCE_EN is defined.
module key_conditioner
`ifdef KEY_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic press_q, press_d;
  logic lvl_c;

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DB_N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CW   = (DB_N > 1) ? $clog2(DB_N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Accept a new level only after DB_N consecutive samples disagree with the current one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DB_N - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign lvl_c = stable_q;
`else
  assign lvl_c = sync2_q;
`endif

  always_comb begin
    sync1_d = key_i;
    sync2_d = sync1_q;
    prev_d  = lvl_c;
    press_d = lvl_c & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_frame_tx.sv
// Two-key command frame transmitter: start bit, 4 code bits LSB first, STOP_CYCLES idle-high guard.
// Optional key debounce enabled by defining KEY_DEBOUNCE_EN.
module key_frame_tx
  import keyproto_pkg::*;
#(
  parameter int unsigned STOP_CYCLES = 2
`ifdef KEY_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_on,
  input  logic key_off,
  output logic data,
  output logic busy,
  output logic frame_done,
  output logic overrun
);

  localparam int unsigned STOP_N = (STOP_CYCLES < 2) ? 2 : STOP_CYCLES;
  localparam int unsigned SCW    = $clog2(STOP_N);

  logic on_press, off_press;

  key_conditioner
`ifdef KEY_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_cond_on (.clk(clk), .rst(rst), .key_i(key_on), .press_o(on_press));

  key_conditioner
`ifdef KEY_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_cond_off (.clk(clk), .rst(rst), .key_i(key_off), .press_o(off_press));

  tx_state_e      state_q, state_d;
  code_t          shift_q, shift_d;
  logic [1:0]     idx_q, idx_d;
  logic [SCW-1:0] stop_q, stop_d;
  logic           pend_vld_q, pend_vld_d;
  code_t          pend_code_q, pend_code_d;
  logic           data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovr_q, ovr_d;

  logic  press_v, press_used, load;
  code_t press_code, load_code;

  // Outputs are computed from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    data_d      = 1'b1;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    ovr_d       = on_press & off_press;
    press_v     = on_press | off_press;
    press_code  = off_press ? CODE_OFF : CODE_ON;
    press_used  = 1'b0;
    load        = 1'b0;
    load_code   = pend_code_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pend_vld_q) begin
          load       = 1'b1;
          pend_vld_d = 1'b0;
        end else if (press_v) begin
          load       = 1'b1;
          load_code  = press_code;
          press_used = 1'b1;
        end
      end
      START: begin
        state_d = BIT;
        data_d  = shift_q[0];
        shift_d = shift_q >> 1;
        idx_d   = 2'd0;
      end
      BIT: begin
        if (idx_q == 2'd3) begin
          state_d = STOP;
          stop_d  = '0;
        end else begin
          data_d  = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 2'd1;
        end
      end
      STOP: begin
        if (stop_q == SCW'(STOP_N - 1)) begin
          if (pend_vld_q) begin
            load       = 1'b1;
            pend_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          stop_d = stop_q + SCW'(1);
          done_d = (stop_d == SCW'(STOP_N - 1));
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d = START;
      shift_d = load_code;
      data_d  = 1'b0;
      busy_d  = 1'b1;
    end

    // Presses not started directly go to the one-entry slot; first-come keeps it.
    if (press_v && !press_used) begin
      if (!pend_vld_d) begin
        pend_vld_d  = 1'b1;
        pend_code_d = press_code;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      stop_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      data_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_key_frame_tx.sv
// Directed self-checking bench for key_frame_tx with a negedge-sampling receiver model.
module tb_key_frame_tx;
  import keyproto_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_on = 1'b0;
  logic key_off = 1'b0;
  logic data, busy, frame_done, overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt = 0;

  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [3:0] rx_sh = '0;
  logic       rx_s = 1'b0;

  key_frame_tx dut (
    .clk(clk), .rst(rst), .key_on(key_on), .key_off(key_off),
    .data(data), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  // Receiver model: start bit, then 4 bits LSB first sampled on negedge.
  always @(negedge clk) begin
    if (!rst) begin
      rx_act = 1'b0;
      rx_cnt = 0;
    end else if (!rx_act) begin
      if (data === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_sh = {data, rx_sh[3:1]};
      rx_cnt++;
      if (rx_cnt == 4) begin
        rx_act = 1'b0;
        if (rx_sh == 4'b1001) rx_s = 1'b1;
        else if (rx_sh == 4'b1010) rx_s = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic go_neg(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) check("sync", 32'(cyc), 32'(k));
  endtask

  task automatic check_frame(input string tag, input code_t code, input int s);
    logic exp_d;
    go_neg(s);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) exp_d = 1'b0;
      else if (i < 5) exp_d = code[2'(i - 1)];
      else exp_d = 1'b1;
      check($sformatf("%s.data%0d", tag, i), 32'(data), 32'(exp_d));
      check($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s.done%0d", tag, i), 32'(frame_done), 32'(i == 6));
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s.data", tag), 32'(data), 32'd1);
      check($sformatf("%s.busy", tag), 32'(busy), 32'd0);
    end
  endtask

  task automatic single_press(input string tag, input logic use_off, input code_t code,
                              input logic exp_s);
    int b;
    b = cyc;
    if (use_off) key_off = 1'b1;
    else key_on = 1'b1;
    go_neg(b + 3);
    key_on  = 1'b0;
    key_off = 1'b0;
    check_frame(tag, code, b + 4);
    @(negedge clk);
    check($sformatf("%s.busy_end", tag), 32'(busy), 32'd0);
    check($sformatf("%s.rx_s", tag), 32'(rx_s), 32'(exp_s));
    expect_idle(tag, 4);
  endtask

  initial begin
    int b, o0;
    repeat (3) @(negedge clk);
    check("rst.data", 32'(data), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(frame_done), 32'd0);
    check("rst.ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    expect_idle("t1_idle", 20);

    single_press("t2_on", 1'b0, CODE_ON, 1'b1);
    single_press("t3_off", 1'b1, CODE_OFF, 1'b0);
    single_press("t2b_on", 1'b0, CODE_ON, 1'b1);

    // Simultaneous presses: OFF wins, ON dropped with one overrun.
    b = cyc;
    o0 = ovr_cnt;
    key_on = 1'b1;
    key_off = 1'b1;
    go_neg(b + 2);
    key_on = 1'b0;
    key_off = 1'b0;
    check_frame("t4_off", CODE_OFF, b + 4);
    expect_idle("t4_idle", 10);
    check("t4.ovr", 32'(ovr_cnt - o0), 32'd1);
    check("t4.rx_s", 32'(rx_s), 32'd0);

    // ON queued during OFF frame, second OFF dropped; frames back-to-back.
    b = cyc;
    o0 = ovr_cnt;
    key_off = 1'b1;
    fork
      begin
        go_neg(b + 2); key_off = 1'b0;
        go_neg(b + 3); key_on = 1'b1;
        go_neg(b + 5); key_off = 1'b1;
        go_neg(b + 6); key_on = 1'b0;
        go_neg(b + 8); key_off = 1'b0;
      end
      begin
        check_frame("t5_off", CODE_OFF, b + 4);
        check_frame("t5_on", CODE_ON, b + 11);
      end
    join
    @(negedge clk);
    check("t5.busy_end", 32'(busy), 32'd0);
    check("t5.ovr", 32'(ovr_cnt - o0), 32'd1);
    check("t5.rx_s", 32'(rx_s), 32'd1);
    expect_idle("t5_idle", 6);

    // Held key: a single frame, no repeat on hold or release.
    b = cyc;
    key_on = 1'b1;
    check_frame("t6_hold", CODE_ON, b + 4);
    expect_idle("t6_held", 20);
    key_on = 1'b0;
    expect_idle("t6_rel", 10);

    // Async reset mid-frame with a pending OFF: nothing resent afterwards.
    b = cyc;
    key_on = 1'b1;
    go_neg(b + 2); key_on = 1'b0;
    go_neg(b + 3); key_off = 1'b1;
    go_neg(b + 5); key_off = 1'b0;
    go_neg(b + 7);
    check("t7.pre_data", 32'(data), 32'd0);
    check("t7.pre_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t7.async_data", 32'(data), 32'd1);
    check("t7.async_busy", 32'(busy), 32'd0);
    go_neg(b + 9);
    rst = 1'b1;
    expect_idle("t7_after", 15);

`ifdef KEY_DEBOUNCE_EN
    // 3-cycle glitch is filtered; a 6-cycle press starts 4 cycles later than undebounced.
    b = cyc;
    key_on = 1'b1;
    go_neg(b + 3); key_on = 1'b0;
    expect_idle("t8_glitch", 15);
    b = cyc;
    key_on = 1'b1;
    go_neg(b + 6); key_on = 1'b0;
    check_frame("t8_deb", CODE_ON, b + 8);
    expect_idle("t8_idle", 10);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
